// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID verification sequencer.
package sysid_pkg;

  // Sequencer states, also exported on the debug port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  // Word select values on sid_address.
  localparam logic SYSID_WORD_ID = 1'b0;
  localparam logic SYSID_WORD_TS = 1'b1;

  // Width of the read-latency down-counter (latencies 0..7).
  localparam int unsigned LAT_W = 3;

endpackage

// File: rtl/sysid_if.sv
// Bus to the sysid control slave.
// Handshake: the master raises sid_read for exactly one cycle with sid_address
// stable; the slave presents the addressed word on sid_readdata READ_LATENCY
// cycles later (same cycle when the latency is 0). There is no ready/wait
// signal, so the master must not issue another read before it has sampled the
// data. sid_readdata carries no meaning outside that one sample cycle.
interface sysid_if;
  logic        sid_address;
  logic        sid_read;
  logic [31:0] sid_readdata;

  modport master (
    output sid_address,
    output sid_read,
    input  sid_readdata
  );

  modport slave (
    input  sid_address,
    input  sid_read,
    output sid_readdata
  );
endinterface

// File: rtl/sysid_verify_ctrl.sv
// Reads the sysid ID and timestamp words after reset (or on request) and
// raises a sticky pass/fail verdict against the build-time expected values.
module sysid_verify_ctrl
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h5BD2_17D1,
  parameter int unsigned READ_LATENCY = 0,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] id_q,
  output logic [31:0] ts_q,
  output state_t      dbg_state,
  sysid_if.master     sid
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY);

  state_t           state_q, state_d;
  logic             word_q, word_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             arm_q, arm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [31:0]      id_d, ts_d;
  logic             sid_read_q, sid_read_d;
  logic             sid_address_q, sid_address_d;
  logic             sample;
  logic             verdict_pass;

  // The ID word is already held in id_q when the timestamp is sampled.
  assign verdict_pass = (id_q == EXPECTED_ID) && (sid.sid_readdata == EXPECTED_TS);

  // Next-state and output computation for the read sequence.
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    lat_cnt_d     = lat_cnt_q;
    arm_d         = arm_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    fail_d        = fail_q;
    id_d          = id_q;
    ts_d          = ts_q;
    sid_read_d    = 1'b0;
    sid_address_d = sid_address_q;
    sample        = 1'b0;

    case (state_q)
      IDLE: begin
        // The one-shot arm flag gives the automatic check after reset;
        // a coincident start request folds into the same sequence.
        if (start || arm_q) begin
          arm_d         = 1'b0;
          state_d       = ISSUE;
          word_d        = SYSID_WORD_ID;
          busy_d        = 1'b1;
          pass_d        = 1'b0;
          fail_d        = 1'b0;
          sid_read_d    = 1'b1;
          sid_address_d = SYSID_WORD_ID;
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_INIT;
        if (LAT_INIT == '0) sample = 1'b1;
        else                state_d = WAIT;
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == LAT_W'(1)) sample = 1'b1;
      end
      CHECK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Read data is only looked at here, so nothing outside the sample cycle
    // can reach the captured words.
    if (sample) begin
      if (word_q == SYSID_WORD_ID) begin
        id_d          = sid.sid_readdata;
        state_d       = ISSUE;
        word_d        = SYSID_WORD_TS;
        sid_read_d    = 1'b1;
        sid_address_d = SYSID_WORD_TS;
      end else begin
        // Verdict is loaded together with done so both appear in CHECK.
        ts_d    = sid.sid_readdata;
        state_d = CHECK;
        done_d  = 1'b1;
        pass_d  = verdict_pass;
        fail_d  = !verdict_pass;
      end
    end
  end

  // State and registered outputs; reset re-arms the automatic check.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      word_q        <= SYSID_WORD_ID;
      lat_cnt_q     <= '0;
      arm_q         <= AUTO_START;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      id_q          <= '0;
      ts_q          <= '0;
      sid_read_q    <= 1'b0;
      sid_address_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      lat_cnt_q     <= lat_cnt_d;
      arm_q         <= arm_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      id_q          <= id_d;
      ts_q          <= ts_d;
      sid_read_q    <= sid_read_d;
      sid_address_q <= sid_address_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail            = fail_q;
  assign dbg_state       = state_q;
  assign sid.sid_read    = sid_read_q;
  assign sid.sid_address = sid_address_q;

endmodule
